xnor_popcount_acc: RTL and testbench
====================================

// Module: xnor_popcount_acc
// PURPOSE
//  Binary-neuron MAC stage: consumes binarized activation vectors (+1/-1, signed
//  target_depth-bit codes) in BEATS beats of WIDTH elements, XNORs them with 1-bit
//  weights and accumulates the signed dot product plus a per-neuron bias. Result is a
//  signed ACC_W-bit raw sum feeding the next binarize stage (ACC_W == its depth).
// PARAMETERS
//  WIDTH         3   elements per input beat
//  target_depth  2   bits per binarized element (two's complement, +1 / -1)
//  BEATS         4   beats per dot product (vector length = WIDTH*BEATS)
//  ACC_W         32  signed accumulator / output width; must be >= clog2(WIDTH*BEATS)+2
// PORTS
//  clk        in   1                     clock, rising edge
//  rst        in   1                     asynchronous reset, active-high
//  in_valid   in   1                     input beat valid
//  in_ready   out  1                     stage can accept a beat
//  in_data    in   target_depth x WIDTH  binarized activations (unpacked array)
//  in_w       in   WIDTH                 weights, bit=1 -> +1, bit=0 -> -1
//  in_bias    in   ACC_W signed          neuron bias, sampled on first beat only
//  out_valid  out  1                     result valid
//  out_ready  in   1                     downstream accepts result
//  out_data   out  ACC_W signed          bias + sum of XNOR products
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE, beat_cnt=0, acc=0, out_valid=0, out_data=0.
//  Element decode: sign bit (MSB) of in_data[i] only; MSB=0 -> +1, MSB=1 -> -1
//   (2'b00 reads as +1, 2'b10 as -1). Product_i = +1 if decoded sign == weight sign
//   else -1. beat_sum = WIDTH - 2*mismatch_count (signed, sign-extended to ACC_W).
//  Transfer on in_valid & in_ready; result handshake on out_valid & out_ready.
//  in_ready = (state != OUT). Gaps in in_valid between beats are allowed, no timeout.
//  FSM:
//   IDLE: beat accepted -> acc = sext(in_bias) + beat_sum; beat_cnt=1; -> ACC
//         (if BEATS==1 go directly to OUT with out_data = that value).
//   ACC : beat accepted -> beat_cnt++; if beat_cnt==BEATS-1 (last beat):
//         out_data <= acc + beat_sum, out_valid<=1, beat_cnt<=0 -> OUT;
//         else acc <= acc + beat_sum. in_bias ignored in ACC.
//   OUT : out_data, out_valid held stable until out_ready=1; on handshake
//         out_valid<=0 -> IDLE. in_ready=0, so no beat accepted in OUT.
//  Latency: out_valid rises the cycle after the last beat is accepted.
//  Throughput: one result per BEATS+1 cycles minimum (one bubble for OUT->IDLE).
//  Arithmetic: two's-complement, wraps modulo 2^ACC_W, no saturation; with legal
//   ACC_W only bias values near the range limits can wrap.
//  Reset mid-vector: partial acc and beat_cnt discarded; next accepted beat is
//   treated as a first beat (bias sampled).
//  out_ready asserted while out_valid=0: ignored.
// TESTING  (WIDTH=3, BEATS=4, ACC_W=32)
//  1. 4 beats in_data all 2'sb01, in_w=3'b111, bias 0 -> out_data=12, 1 cycle after beat 4.
//  2. 4 beats in_data all 2'sb01, in_w=3'b000, bias 5 -> out_data=-7.
//  3. Mixed: beats with one mismatch each (in_w=3'b011, data +1), bias -2 -> 4*1-2=2.
//  4. Back-pressure: out_ready=0 for 5 cycles -> out_data/out_valid stable, in_ready=0,
//     extra in_valid beats not consumed; after release next vector result correct.
//  5. in_valid toggled 1/0 between beats (bias changes on non-first beats) -> same
//     result as back-to-back case 1/2; bias only from first beat.
//  6. rst pulse after 2 beats, then full vector of case 2 -> out_data=-7; codes 2'b00/2'b10
//     with in_w=3'b111 yield +1/-1 per element respectively.

Source files
------------

// File: rtl/xnor_popcount_acc.sv
// Binary-neuron MAC stage: XNORs binarized activations with 1-bit weights over
// BEATS beats of WIDTH elements and returns bias + signed dot product.
module xnor_popcount_acc #(
  parameter int WIDTH        = 3,
  parameter int target_depth = 2,
  parameter int BEATS        = 4,
  parameter int ACC_W        = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic signed [target_depth-1:0] in_data [WIDTH],
  input  logic        [WIDTH-1:0]        in_w,
  input  logic signed [ACC_W-1:0]        in_bias,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic signed [ACC_W-1:0]        out_data,
  output logic        [1:0]              dbg_state
);

  // Handshake: a beat transfers on in_valid & in_ready, a result on
  // out_valid & out_ready; out_valid/out_data never change while waiting.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int MM_W  = $clog2(WIDTH + 1);

  state_t                   r_state;
  state_t                   w_next;
  logic [CNT_W-1:0]         r_beat_cnt;
  logic signed [ACC_W-1:0]  r_acc;
  logic signed [ACC_W-1:0]  r_out_data;
  logic                     r_out_valid;
  logic [MM_W-1:0]          w_mm;
  logic                     w_unused_lsbs;
  logic signed [ACC_W-1:0]  w_beat_sum;
  logic signed [ACC_W-1:0]  w_base;
  logic signed [ACC_W-1:0]  w_sum;
  logic                     w_fire;
  logic                     w_last;

  // Only the sign bit of each code matters; product is -1 when the decoded
  // activation sign equals the weight bit (MSB=1 is -1, weight 1 is +1).
  always_comb begin
    w_mm          = '0;
    w_unused_lsbs = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      w_mm          = w_mm + MM_W'(in_data[i][target_depth-1] == in_w[i]);
      w_unused_lsbs = w_unused_lsbs ^ (^in_data[i][target_depth-2:0]);
    end
  end

  assign w_beat_sum = ACC_W'(WIDTH) - (ACC_W'(w_mm) << 1);
  assign in_ready   = (r_state != OUT);
  assign w_fire     = in_valid & in_ready;
  assign w_base     = (r_state == IDLE) ? in_bias : r_acc;
  assign w_sum      = w_base + w_beat_sum;
  assign w_last     = (r_state == IDLE) ? (BEATS == 1)
                                        : (r_beat_cnt == CNT_W'(BEATS - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, ACC: if (w_fire) w_next = w_last ? OUT : ACC;
      OUT:       if (out_ready) w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_beat_cnt  <= '0;
      r_acc       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_fire) begin
        if (w_last) begin
          r_out_data  <= w_sum;
          r_out_valid <= 1'b1;
          r_beat_cnt  <= '0;
        end else begin
          r_acc      <= w_sum;
          r_beat_cnt <= (r_state == IDLE) ? CNT_W'(1) : r_beat_cnt + CNT_W'(1);
        end
      end
      if (r_state == OUT && out_ready) r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_xnor_popcount_acc.sv
// Directed bench for xnor_popcount_acc (WIDTH=3, BEATS=4, ACC_W=32) with
// hand-computed expected sums checked through immediate assertions.
module tb_xnor_popcount_acc;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic signed [1:0] in_data [3];
  logic [2:0]        in_w;
  logic signed [31:0] in_bias;
  logic              out_valid;
  logic              out_ready;
  logic signed [31:0] out_data;
  logic [1:0]        dbg_state;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  xnor_popcount_acc #(
    .WIDTH(3), .target_depth(2), .BEATS(4), .ACC_W(32)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_w(in_w), .in_bias(in_bias),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .dbg_state(dbg_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  // One beat: present at negedge, wait (bounded) for in_ready, transfer on posedge.
  task automatic send_beat(input logic [1:0] d0, input logic [1:0] d1, input logic [1:0] d2,
                           input logic [2:0] w, input logic [31:0] bias);
    int k;
    @(negedge clk);
    in_data[0] = d0;
    in_data[1] = d1;
    in_data[2] = d2;
    in_w       = w;
    in_bias    = bias;
    in_valid   = 1'b1;
    k = 0;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Four identical beats; bias on beats 2..4 is junk that must be ignored.
  task automatic send_vec(input string tag, input logic [1:0] d, input logic [2:0] w,
                          input logic [31:0] bias, input int gap);
    for (int b = 0; b < 4; b++) begin
      send_beat(d, d, d, w, (b == 0) ? bias : 32'd100 + 32'(b));
      if (b == 2) chk({tag, "_early_valid"}, {31'd0, out_valid}, 32'd0);
      if (b < 3) repeat (gap) @(posedge clk);
    end
  endtask

  // Called #1 after the last beat's edge: result must already be valid.
  task automatic expect_result(input string tag, input logic [31:0] exp);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_data"}, out_data, exp);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_ready_back"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    in_data[0] = 2'b00;
    in_data[1] = 2'b00;
    in_data[2] = 2'b00;
    in_w       = 3'b000;
    in_bias    = 32'sd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_state", {30'd0, dbg_state}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // all +1 data, all +1 weights: 4*3 = 12
    send_vec("c1", 2'b01, 3'b111, 32'd0, 0);
    expect_result("c1", 32'd12);

    // all mismatches: -12 + 5 = -7
    send_vec("c2", 2'b01, 3'b000, 32'd5, 0);
    expect_result("c2", -32'sd7);

    // one mismatch per beat: 4*1 - 2 = 2
    send_vec("c3", 2'b01, 3'b011, -32'sd2, 0);
    expect_result("c3", 32'd2);

    // out_ready while nothing is pending is ignored
    @(negedge clk);
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("idle_ready_valid", {31'd0, out_valid}, 32'd0);
    chk("idle_ready_state", {30'd0, dbg_state}, 32'd0);
    out_ready = 1'b0;

    // back-pressure: hold 5 cycles with junk beats offered
    send_vec("c4", 2'b01, 3'b111, 32'd0, 0);
    @(negedge clk);
    in_data[0] = 2'b11;
    in_data[1] = 2'b11;
    in_data[2] = 2'b11;
    in_w       = 3'b000;
    in_bias    = 32'd1000;
    in_valid   = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_data", out_data, 32'd12);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    expect_result("c4", 32'd12);
    send_vec("c4_next", 2'b01, 3'b000, 32'd5, 0);
    expect_result("c4_next", -32'sd7);

    // gaps between beats
    send_vec("c5a", 2'b01, 3'b111, 32'd0, 2);
    expect_result("c5a", 32'd12);
    send_vec("c5b", 2'b01, 3'b000, 32'd5, 1);
    expect_result("c5b", -32'sd7);

    // reset after two beats discards the partial vector
    send_beat(2'b01, 2'b01, 2'b01, 3'b111, 32'd50);
    send_beat(2'b01, 2'b01, 2'b01, 3'b111, 32'd50);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_state", {30'd0, dbg_state}, 32'd0);
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    send_vec("c6", 2'b01, 3'b000, 32'd5, 0);
    expect_result("c6", -32'sd7);

    // code decode: 2'b00 is +1, 2'b10 is -1
    send_vec("c6_00", 2'b00, 3'b111, 32'd0, 0);
    expect_result("c6_00", 32'd12);
    send_vec("c6_10", 2'b10, 3'b111, 32'd0, 0);
    expect_result("c6_10", -32'sd12);
    for (int b = 0; b < 4; b++)
      send_beat(2'b00, 2'b10, 2'b11, 3'b101, (b == 0) ? 32'd3 : 32'd77);
    // per beat: +1*+1, -1*-1, -1*+1 -> +1 +1 -1 = 1; 4 + 3 = 7
    expect_result("mixed", 32'd7);

    // wrap near the positive limit
    send_vec("wrap", 2'b01, 3'b111, 32'h7FFF_FFFF, 0);
    expect_result("wrap", 32'h8000_000B);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
